spi_read_master: RTL and testbench



---
 rtl/spi_read_pkg.sv | 19 +
 rtl/spi_sclk_gen.sv | 63 ++++++
 rtl/spi_read_master.sv | 111 +++++++++++
 tb/tb_spi_read_master.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_read_pkg.sv
// Shared state encoding and default frame geometry for the SPI read master.
package spi_read_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_HALF_DIV   = 2;
    localparam int DEF_GAP_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: DATA_W periods of HALF_DIV cycles high then HALF_DIV low, started by start, held by run.
// sclk is registered; rise/done flag the clk edge that changes it; no backpressure.
module spi_sclk_gen
    import spi_read_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int HALF_DIV = DEF_HALF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic done
);

    localparam int HW = $clog2(HALF_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);

    logic [HW-1:0] half_cnt;
    logic [BW-1:0] bit_cnt;
    logic          half_end;
    logic          last_bit;

    assign half_end = (half_cnt == HW'(HALF_DIV - 1));
    assign last_bit = (bit_cnt == BW'(DATA_W - 1));

    // start raises sclk on the same edge the FSM enters SHIFT, so that edge is the first sample point
    assign rise = start | (run & ~sclk & half_end & ~last_bit);
    assign done = run & ~sclk & half_end & last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start) begin
            sclk     <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
        end else if (run) begin
            if (!half_end) begin
                half_cnt <= half_cnt + HW'(1);
            end else begin
                half_cnt <= '0;
                if (sclk) begin
                    sclk <= 1'b0;
                end else if (last_bit) begin
                    bit_cnt <= '0;
                end else begin
                    sclk    <= 1'b1;
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end else begin
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
        end
    end

endmodule

// File: rtl/spi_read_master.sv
// Free-running SPI mode-0 read master: one word every GAP_CYCLES + (2*DATA_W+2)*HALF_DIV cycles, all outputs registered.
// No backpressure; define SPI_LSB_FIRST_EN to place the first sampled bit in data_out[0].
module spi_read_master
    import spi_read_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int HALF_DIV   = DEF_HALF_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miso,
    output logic              cs,
    output logic              sclk,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int CW = $clog2(max_int(GAP_CYCLES, HALF_DIV) + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              gap_end;
    logic              half_end;
    logic              start;
    logic              run;
    logic              rise;
    logic              done;

    assign gap_end  = (cnt == CW'(GAP_CYCLES - 1));
    assign half_end = (cnt == CW'(HALF_DIV - 1));
    assign start    = (state == SETUP) & half_end;
    assign run      = (state == SHIFT);

    spi_sclk_gen #(
        .DATA_W   (DATA_W),
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .run   (run),
        .sclk  (sclk),
        .rise  (rise),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cs         <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            shreg      <= '0;
        end else begin
            data_valid <= 1'b0;
            // miso has been stable since the previous sclk fall, so sample as sclk goes high
            if (rise) begin
`ifdef SPI_LSB_FIRST_EN
                shreg <= {miso, shreg[DATA_W-1:1]};
`else
                shreg <= {shreg[DATA_W-2:0], miso};
`endif
            end
            case (state)
                IDLE: begin
                    if (gap_end) begin
                        cnt   <= '0;
                        cs    <= 1'b0;
                        state <= SETUP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (done) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        cnt        <= '0;
                        cs         <= 1'b1;
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    cs    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_read_master.sv
// Bench for spi_read_master: default instance plus a HALF_DIV=1/GAP_CYCLES=1 instance, both against a cycle-position model.
module tb_spi_read_master;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rst_b_n;
    logic          miso_a, cs_a, sclk_a, dv_a;
    logic          miso_b, cs_b, sclk_b, dv_b;
    logic [DW-1:0] dout_a, dout_b;

    always #5 clk = ~clk;

    spi_read_master #(.DATA_W(DW), .HALF_DIV(2), .GAP_CYCLES(4)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .miso       (miso_a),
        .cs         (cs_a),
        .sclk       (sclk_a),
        .data_out   (dout_a),
        .data_valid (dv_a)
    );

    spi_read_master #(.DATA_W(DW), .HALF_DIV(1), .GAP_CYCLES(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_b_n),
        .miso       (miso_b),
        .cs         (cs_b),
        .sclk       (sclk_b),
        .data_out   (dout_b),
        .data_valid (dv_b)
    );

    int            n_assert = 0;
    int            n_fail   = 0;
    int            t_cnt[2];
    int            rises[2];
    int            frames_done[2];
    logic          prev_sclk[2];
    logic [DW-1:0] model_dout[2];
    logic [DW-1:0] inflight[2];
    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];
    logic [DW-1:0] tx_a, tx_b;
    int            idx_a = -1;
    int            idx_b = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The slave always sends bit 7 first; the word the master should assemble depends on the build.
    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w);
        logic [DW-1:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    // Slave models: first bit presented at cs fall, next bit after every sclk fall.
    always @(negedge cs_a) begin
        tx_a        = (q_a.size() > 0) ? q_a.pop_front() : DW'($urandom);
        inflight[0] = tx_a;
        idx_a       = DW - 1;
        miso_a      = tx_a[idx_a];
    end
    always @(negedge sclk_a) if (cs_a === 1'b0) begin
        idx_a--;
        if (idx_a >= 0) miso_a = tx_a[idx_a];
    end
    always @(negedge cs_b) begin
        tx_b        = (q_b.size() > 0) ? q_b.pop_front() : DW'($urandom);
        inflight[1] = tx_b;
        idx_b       = DW - 1;
        miso_b      = tx_b[idx_b];
    end
    always @(negedge sclk_b) if (cs_b === 1'b0) begin
        idx_b--;
        if (idx_b >= 0) miso_b = tx_b[idx_b];
    end

    // Expected waveform from the position t inside the frame period counted from reset release.
    task automatic step(input int d, input int h, input int g, input logic r, input logic cs,
                        input logic sc, input logic dv, input logic [DW-1:0] dout);
        int    p, f, gp;
        logic  ecs, esc, edv;
        string nm;
        nm = (d == 0) ? "a" : "b";
        if (!r) begin
            t_cnt[d]      = 0;
            rises[d]      = 0;
            prev_sclk[d]  = 1'b0;
            model_dout[d] = '0;
            check({nm, "_rst_cs"}, 32'(cs), 32'd1);
            check({nm, "_rst_sclk"}, 32'(sc), 32'd0);
            check({nm, "_rst_dv"}, 32'(dv), 32'd0);
            check({nm, "_rst_dout"}, 32'(dout), 32'd0);
            return;
        end
        t_cnt[d]++;
        p   = g + (2 * DW + 2) * h;
        f   = t_cnt[d] % p;
        gp  = f - g - h;
        ecs = (f < g);
        esc = (gp >= 0) && (gp < 2 * h * DW) && ((gp % (2 * h)) < h);
        edv = (f == 0);
        if (sc && !prev_sclk[d] && !cs) rises[d]++;
        prev_sclk[d] = sc;
        if (edv) begin
            model_dout[d] = exp_word(inflight[d]);
            check({nm, "_rises_per_frame"}, 32'(rises[d]), 32'(DW));
            rises[d] = 0;
            frames_done[d]++;
        end
        check({nm, "_cs"}, 32'(cs), 32'(ecs));
        check({nm, "_sclk"}, 32'(sc), 32'(esc));
        check({nm, "_dv"}, 32'(dv), 32'(edv));
        check({nm, "_dout"}, 32'(dout), 32'(model_dout[d]));
        check({nm, "_sclk_while_cs_high"}, 32'(sc & cs), 32'd0);
        check({nm, "_dv_while_cs_low"}, 32'(dv & ~cs), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        step(0, 2, 4, rst_n, cs_a, sclk_a, dv_a, dout_a);
        step(1, 1, 1, rst_b_n, cs_b, sclk_b, dv_b, dout_b);
    end

    initial begin
        int found;
        int frames_before;
        for (int i = 0; i < 2; i++) begin
            t_cnt[i]       = 0;
            rises[i]       = 0;
            frames_done[i] = 0;
            prev_sclk[i]   = 1'b0;
            model_dout[i]  = '0;
            inflight[i]    = '0;
        end
        q_a     = '{8'hA5, 8'h01, 8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h96, 8'h77, 8'h55};
        q_b     = '{8'h5A, 8'h81, 8'hFF, 8'h00};
        miso_a  = 1'b0;
        miso_b  = 1'b0;
        rst_n   = 1'b1;
        rst_b_n = 1'b1;
        #2;
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        rst_b_n = 1'b1;

        // Seven complete frames on the default instance: directed words then 0x96.
        repeat (7 * 40) @(negedge clk);
        check("a_frames_before_abort", 32'(frames_done[0]), 32'd7);

        // Abort the eighth frame (word 0x77) in its 5th sclk period.
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (t_cnt[0] % 40 == 23) begin
                found = 1;
                break;
            end
        end
        check("a_reach_5th_period", 32'(found), 32'd1);
        check("a_pre_abort_sclk", 32'(sclk_a), 32'd1);
        check("a_pre_abort_dout", 32'(dout_a), 32'(exp_word(8'h96)));
        rst_n = 1'b0;
        #1;
        check("a_abort_cs", 32'(cs_a), 32'd1);
        check("a_abort_sclk", 32'(sclk_a), 32'd0);
        check("a_abort_dout", 32'(dout_a), 32'd0);
        check("a_abort_dv", 32'(dv_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frames_before = frames_done[0];

        // Three frames after release: 0x55 first, then random words.
        repeat (3 * 40 + 2) @(negedge clk);
        check("a_frames_after_abort", 32'(frames_done[0] - frames_before), 32'd3);
        check("b_frames_total", 32'(frames_done[1] >= 20), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
